// File: rtl/range_stream_driver_if.sv
// Host/consumer bundle for range_stream_driver: buffer writes, replay stream, range return and status.
interface range_stream_driver_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH+1)
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clr;
    logic             start;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;
    logic             busy;
    logic             done;
    logic             go;
    logic             finish;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] range_in;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             start_err;
    logic             mismatch;

    modport master (
        output wr_en, wr_data, clr, start, range_in,
        input  count, full, overflow, busy, done, go, finish, data_out,
               result, result_valid, start_err, mismatch
    );

    modport slave (
        input  wr_en, wr_data, clr, start, range_in,
        output count, full, overflow, busy, done, go, finish, data_out,
               result, result_valid, start_err, mismatch
    );
endinterface

// File: rtl/range_stream_driver.sv
// Buffers host samples and replays them as one go/data/finish stream, capturing the returned range.
// Define RANGE_DRV_CHECK_EN to compare the returned range against the replayed samples' max-min.
module range_stream_driver #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic                 clock,
    input  logic                 reset,
    range_stream_driver_if.slave bus
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FIRST, STREAM, FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             serr_q, serr_d;
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] sample;
    logic             wr_ok;
    logic             launch;

    assign sample = mem_q[idx_q];

    // Sample storage carries no reset; only count defines what is valid.
    always_ff @(posedge clock) begin
        if (wr_ok) mem_q[count_q[AW-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            serr_q   <= 1'b0;
            rv_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            serr_q   <= serr_d;
            rv_q     <= rv_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        serr_d   = 1'b0;
        rv_d     = rv_q;
        result_d = result_q;
        wr_ok    = 1'b0;
        launch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (bus.wr_en) begin
                    if (count_q == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_ok   = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                end
                // Start sees the post-write count so a same-cycle write joins the run.
                if (bus.start) begin
                    if (count_d == '0) begin
                        serr_d = 1'b1;
                    end else begin
                        launch  = 1'b1;
                        state_d = FIRST;
                        idx_d   = '0;
                        rv_d    = 1'b0;
                    end
                end
            end
            FIRST: begin
                idx_d   = idx_q + AW'(1);
                state_d = (count_q == CW'(1)) ? FIN : STREAM;
            end
            STREAM: begin
                if (CW'(idx_q) == count_q - CW'(1)) state_d = FIN;
                else                                idx_d   = idx_q + AW'(1);
            end
            FIN: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                rv_d     = 1'b1;
                result_d = bus.range_in;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.count        = count_q;
    assign bus.full         = (count_q == FULL_CNT);
    assign bus.overflow     = ovf_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.go           = (state_q == FIRST);
    assign bus.finish       = (state_q == FIN);
    assign bus.data_out     = (state_q == FIRST || state_q == STREAM) ? sample : '0;
    assign bus.result       = result_q;
    assign bus.result_valid = rv_q;
    assign bus.start_err    = serr_q;

`ifdef RANGE_DRV_CHECK_EN
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic             mm_q, mm_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
            mm_q  <= 1'b0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
            mm_q  <= mm_d;
        end
    end

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        mm_d  = mm_q;
        if (launch) mm_d = 1'b0;
        case (state_q)
            FIRST: begin
                min_d = sample;
                max_d = sample;
            end
            STREAM: begin
                if (sample < min_q) min_d = sample;
                if (sample > max_q) max_d = sample;
            end
            FIN:     mm_d = (bus.range_in != (max_q - min_q));
            default: ;
        endcase
    end

    assign bus.mismatch = mm_q;
`else
    assign bus.mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_range_stream_driver.sv
// Randomized bench for range_stream_driver against a queue-based model of the buffer and stream.
module tb_range_stream_driver;
    localparam int WIDTH = 10;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH+1);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    range_stream_driver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();
    range_stream_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [WIDTH-1:0] q [$];
    bit               m_ovf, m_rv, m_mm;
    logic [WIDTH-1:0] m_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] spread();
        logic [WIDTH-1:0] mn, mx;
        mn = q[0];
        mx = q[0];
        foreach (q[i]) begin
            if (q[i] < mn) mn = q[i];
            if (q[i] > mx) mx = q[i];
        end
        return mx - mn;
    endfunction

    task automatic idle_in();
        bus.wr_en = 1'b0;
        bus.clr   = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic write(input logic [WIDTH-1:0] v);
        bus.wr_en   = 1'b1;
        bus.wr_data = v;
        if (q.size() < DEPTH) q.push_back(v);
        else                  m_ovf = 1'b1;
        @(negedge clock);
        bus.wr_en = 1'b0;
        chk("wr_count", bus.count, q.size());
        chk("wr_ovf", bus.overflow, m_ovf);
        chk("wr_full", bus.full, q.size() == DEPTH);
    endtask

    task automatic clear(input bit with_wr);
        bus.clr     = 1'b1;
        bus.wr_en   = with_wr;
        bus.wr_data = WIDTH'($urandom);
        q.delete();
        m_ovf = 1'b0;
        @(negedge clock);
        idle_in();
        chk("clr_count", bus.count, 0);
        chk("clr_ovf", bus.overflow, 0);
    endtask

    task automatic empty_start();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        chk("serr_pulse", bus.start_err, 1);
        chk("serr_busy", bus.busy, 0);
        chk("serr_go", bus.go, 0);
        @(negedge clock);
        chk("serr_end", bus.start_err, 0);
        chk("serr_busy2", bus.busy, 0);
        chk("serr_go2", bus.go, 0);
    endtask

    // Replays the model queue; range_in is the golden spread unless forced.
    task automatic run(input bit frc, input logic [WIDTH-1:0] frng,
                       input bit with_wr, input logic [WIDTH-1:0] wv, input bit junk);
        int n;
        logic [WIDTH-1:0] rng;
        bus.start = 1'b1;
        if (with_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = wv;
            if (q.size() < DEPTH) q.push_back(wv);
            else                  m_ovf = 1'b1;
        end
        n   = q.size();
        rng = frc ? frng : spread();
        bus.range_in = rng;
        @(negedge clock);
        idle_in();
        for (int i = 0; i < n; i++) begin
            chk("go", bus.go, i == 0);
            chk("data", bus.data_out, q[i]);
            chk("fin_early", bus.finish, 0);
            chk("busy", bus.busy, 1);
            if (i == 0) chk("rv_drop", bus.result_valid, 0);
            if (junk) begin
                bus.wr_en   = 1'($urandom);
                bus.wr_data = WIDTH'($urandom);
                bus.clr     = 1'($urandom);
                bus.start   = 1'($urandom);
            end
            @(negedge clock);
        end
        chk("finish", bus.finish, 1);
        chk("fin_go", bus.go, 0);
        chk("fin_data", bus.data_out, 0);
        chk("fin_done", bus.done, 0);
        m_res = rng;
        m_rv  = 1'b1;
`ifdef RANGE_DRV_CHECK_EN
        m_mm = (rng != spread());
`else
        m_mm = 1'b0;
`endif
        @(negedge clock);
        idle_in();
        chk("done", bus.done, 1);
        chk("result", bus.result, m_res);
        chk("rv", bus.result_valid, m_rv);
        chk("idle_busy", bus.busy, 0);
        chk("mismatch", bus.mismatch, m_mm);
        chk("run_count", bus.count, q.size());
        chk("run_ovf", bus.overflow, m_ovf);
        chk("idle_fin", bus.finish, 0);
        chk("idle_go", bus.go, 0);
        @(negedge clock);
        chk("done_end", bus.done, 0);
    endtask

    initial begin
        idle_in();
        bus.wr_data  = '0;
        bus.range_in = '0;
        m_ovf = 1'b0; m_rv = 1'b0; m_mm = 1'b0; m_res = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_count", bus.count, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_go", bus.go, 0);
        chk("rst_finish", bus.finish, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_serr", bus.start_err, 0);
        chk("rst_mm", bus.mismatch, 0);

        // 5,9,2,7 with golden range 7
        write(5); write(9); write(2); write(7);
        run(1'b0, '0, 1'b0, '0, 1'b0);
        chk("golden7", bus.result, 7);

        // single sample: FIRST straight to FIN, range 0
        clear(1'b0);
        write(300);
        run(1'b1, '0, 1'b0, '0, 1'b0);

        // fill, drop one, replay with busy-time noise, clear with a racing write
        clear(1'b0);
        for (int i = 0; i < DEPTH; i++) write(WIDTH'($urandom));
        write(10'h3ff);
        chk("ovf_full", bus.full, 1);
        chk("ovf_count", bus.count, DEPTH);
        run(1'b0, '0, 1'b0, '0, 1'b1);
        clear(1'b1);

        empty_start();

        // write in the same cycle as start joins the run
        for (int i = 0; i < 3; i++) write(WIDTH'($urandom));
        run(1'b0, '0, 1'b1, WIDTH'($urandom), 1'b0);

        // reset during STREAM at sample 3 of 8
        clear(1'b0);
        for (int i = 0; i < 8; i++) write(WIDTH'($urandom));
        bus.range_in = spread();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("pre_rst_data", bus.data_out, q[i]);
            if (i < 3) @(negedge clock);
        end
        #1 reset = 1'b1;
        q.delete();
        m_ovf = 1'b0; m_rv = 1'b0; m_mm = 1'b0; m_res = '0;
        #1;
        chk("arst_go", bus.go, 0);
        chk("arst_finish", bus.finish, 0);
        chk("arst_data", bus.data_out, 0);
        chk("arst_count", bus.count, 0);
        chk("arst_rv", bus.result_valid, 0);
        chk("arst_busy", bus.busy, 0);
        #1 reset = 1'b0;
        @(negedge clock);
        empty_start();
        chk("arst_result", bus.result, m_res);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            int n;
            clear(1'b0);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) write(WIDTH'($urandom));
            run(1'($urandom), WIDTH'($urandom), 1'b0, '0, 1'($urandom));
        end

        // self-check: wrong range then correct range
        clear(1'b0);
        write(100); write(900);
        run(1'b1, 5, 1'b0, '0, 1'b0);
        run(1'b0, '0, 1'b0, '0, 1'b0);
        chk("range800", bus.result, 800);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
